// File: rtl/pol_ofm_rsp.sv
// Pooling responder: accepts index requests, issues fixed-latency OFM SRAM reads and
// returns the read vectors in order on a credit-protected valid/ready stream.

module pol_ofm_rsp_chk (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic pop,
  input logic full
);
  // A push onto a full buffer without a same-cycle pop would lose a vector.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop))
    else $error("pol_ofm_rsp return buffer overflow");
endmodule

module pol_ofm_rsp #(
  parameter int IDX_WIDTH            = 10,
  parameter int SRAM_ADDR_WIDTH      = 12,
  parameter int ACT_WIDTH            = 8,
  parameter int POOL_COMP_CORE       = 64,
  parameter int POOL_MAP_DEPTH_WIDTH = 5,
  parameter int RD_LATENCY           = 2,
  parameter int RSP_DEPTH            = RD_LATENCY + 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                Rst,
  input  logic [SRAM_ADDR_WIDTH-1:0]          CfgBaseAddr,
  input  logic [POOL_MAP_DEPTH_WIDTH-1:0]     CfgK,
  input  logic                                AddrVld,
  input  logic [IDX_WIDTH-1:0]                Addr,
  output logic                                AddrRdy,
  output logic                                RdEn,
  output logic [SRAM_ADDR_WIDTH-1:0]          RdAddr,
  input  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] RdDat,
  output logic                                OfmVld,
  output logic [ACT_WIDTH*POOL_COMP_CORE-1:0] Ofm,
  output logic                                OfmLast,
  input  logic                                OfmRdy
);
  localparam int DW = ACT_WIDTH * POOL_COMP_CORE;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int KW = POOL_MAP_DEPTH_WIDTH;
  localparam logic [CW-1:0] DEPTH_C    = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_PTR_C = PW'(RSP_DEPTH - 1);

  logic [CW-1:0]         credit_r;
  logic [CW-1:0]         count_r;
  logic [RD_LATENCY-1:0] vpipe_r;
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [KW-1:0]         grp_r;
  logic [DW-1:0]         mem_r [RSP_DEPTH];

  logic addr_rdy_s;
  logic issue_s;
  logic ofm_vld_s;
  logic pop_s;
  logic push_s;
  logic last_hit_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == LAST_PTR_C) ? '0 : p + PW'(1);
  endfunction

  // Handshake qualifiers; both resets force every valid/ready low immediately.
  always_comb begin
    addr_rdy_s = rst_n && !Rst && (credit_r != '0);
    issue_s    = AddrVld && addr_rdy_s;
    ofm_vld_s  = rst_n && !Rst && (count_r != '0);
    pop_s      = ofm_vld_s && OfmRdy;
    push_s     = vpipe_r[RD_LATENCY-1] && !Rst;
    if (CfgK <= KW'(1)) begin
      last_hit_s = 1'b1;
    end else begin
      last_hit_s = (grp_r == CfgK - KW'(1));
    end
  end

  // Credits, read-valid pipe, buffer pointers and group counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_r <= DEPTH_C;
      count_r  <= '0;
      vpipe_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      grp_r    <= '0;
    end else if (Rst) begin
      credit_r <= DEPTH_C;
      count_r  <= '0;
      vpipe_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      grp_r    <= '0;
    end else begin
      vpipe_r[0] <= issue_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vpipe_r[i] <= vpipe_r[i-1];
      end
      case ({issue_s, pop_s})
        2'b10:   credit_r <= credit_r - CW'(1);
        2'b01:   credit_r <= credit_r + CW'(1);
        default: credit_r <= credit_r;
      endcase
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
        grp_r    <= last_hit_s ? '0 : grp_r + KW'(1);
      end
    end
  end

  // Return-buffer storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= RdDat;
    end
  end

  assign AddrRdy = addr_rdy_s;
  assign RdEn    = issue_s;
  assign RdAddr  = CfgBaseAddr + SRAM_ADDR_WIDTH'(Addr);
  assign OfmVld  = ofm_vld_s;
  assign Ofm     = mem_r[rd_ptr_r];
  assign OfmLast = ofm_vld_s && last_hit_s;

  pol_ofm_rsp_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .full  (count_r == DEPTH_C)
  );
endmodule

// File: tb/tb_pol_ofm_rsp.sv
// Directed table plus sequences and a random scoreboard run for pol_ofm_rsp.

module tb_pol_ofm_rsp;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         Rst;
  logic [11:0]  CfgBaseAddr;
  logic [4:0]   CfgK;
  logic         AddrVld;
  logic [9:0]   Addr;
  logic         AddrRdy;
  logic         RdEn;
  logic [11:0]  RdAddr;
  logic [511:0] RdDat;
  logic         OfmVld;
  logic [511:0] Ofm;
  logic         OfmLast;
  logic         OfmRdy;

  int n_chk  = 0;
  int n_fail = 0;
  int pop_idx = 0;
  int n_pop = 0;
  logic [511:0] exp_q[$];
  logic         prev_hold = 1'b0;
  logic [511:0] prev_ofm;
  logic         prev_last;
  logic [11:0]  sa1, sa2;

  always #5 clk = ~clk;

  pol_ofm_rsp dut (
    .clk(clk), .rst_n(rst_n), .Rst(Rst), .CfgBaseAddr(CfgBaseAddr), .CfgK(CfgK),
    .AddrVld(AddrVld), .Addr(Addr), .AddrRdy(AddrRdy), .RdEn(RdEn), .RdAddr(RdAddr),
    .RdDat(RdDat), .OfmVld(OfmVld), .Ofm(Ofm), .OfmLast(OfmLast), .OfmRdy(OfmRdy)
  );

  function automatic logic [511:0] word(input logic [11:0] a);
    logic [15:0] h;
    h = {a[3:0] ^ 4'hC, a};
    word = {32{h}};
  endfunction

  // SRAM model: data for the address presented two cycles earlier.
  always @(posedge clk) begin
    sa1 <= RdAddr;
    sa2 <= sa1;
  end
  assign RdDat = word(sa2);

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard and protocol checks, called once per cycle at the falling edge.
  task automatic monitor();
    logic [11:0] ea;
    logic        el;
    if (!rst_n || Rst) begin
      exp_q.delete();
      pop_idx = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_vld", 512'(OfmVld), 512'(1'b1));
        chk("hold_ofm", Ofm, prev_ofm);
        chk("hold_last", 512'(OfmLast), 512'(prev_last));
      end
      if (AddrVld && AddrRdy) begin
        ea = CfgBaseAddr + {2'b00, Addr};
        chk("issue_rd_en", 512'(RdEn), 512'(1'b1));
        chk("issue_rd_addr", 512'(RdAddr), 512'(ea));
        exp_q.push_back(word(ea));
      end
      if (OfmVld && OfmRdy) begin
        el = (CfgK <= 5'd1) ? 1'b1 : ((pop_idx % int'(CfgK)) == int'(CfgK) - 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 512'(1'b1), 512'(1'b0));
        end else begin
          chk("pop_data", Ofm, exp_q.pop_front());
          chk("pop_last", 512'(OfmLast), 512'(el));
        end
        pop_idx++;
        n_pop++;
      end
      prev_hold = OfmVld && !OfmRdy;
      prev_ofm  = Ofm;
      prev_last = OfmLast;
    end
  endtask

  task automatic adv();
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse(input logic [4:0] k, input logic [11:0] base);
    Rst = 1'b1; AddrVld = 1'b0; CfgK = k; CfgBaseAddr = base;
    @(negedge clk);
    adv();
    Rst = 1'b0;
  endtask

  typedef struct {
    logic rst; logic [4:0] k; logic [11:0] base; logic vld; logic [9:0] addr; logic ordy;
    logic e_rdy; logic e_en; logic [11:0] e_raddr; logic e_ovld; logic e_last;
  } vec_t;
  vec_t tbl[25];

  function automatic vec_t mk(input logic rst, input logic [4:0] k, input logic [11:0] base,
                              input logic vld, input logic [9:0] addr, input logic ordy,
                              input logic e_rdy, input logic e_en, input logic [11:0] e_raddr,
                              input logic e_ovld, input logic e_last);
    vec_t v;
    v.rst = rst; v.k = k; v.base = base; v.vld = vld; v.addr = addr; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_en = e_en; v.e_raddr = e_raddr; v.e_ovld = e_ovld; v.e_last = e_last;
    return v;
  endfunction

  initial begin
    int acc;
    int pops0;
    // single request latency, base 0x100, K=4
    tbl[0]  = mk(0, 5'd4, 12'h100, 1, 10'h005, 1, 1, 1, 12'h105, 0, 0);
    tbl[1]  = mk(0, 5'd4, 12'h100, 0, 10'h000, 1, 1, 0, 12'h000, 0, 0);
    tbl[2]  = mk(0, 5'd4, 12'h100, 0, 10'h000, 1, 1, 0, 12'h000, 0, 0);
    tbl[3]  = mk(0, 5'd4, 12'h100, 0, 10'h000, 1, 1, 0, 12'h000, 1, 0);
    tbl[4]  = mk(0, 5'd4, 12'h100, 0, 10'h000, 1, 1, 0, 12'h000, 0, 0);
    // backpressure with K=1: four accepts, then a single pop returns one credit
    tbl[5]  = mk(1, 5'd1, 12'h000, 1, 10'h010, 0, 0, 0, 12'h000, 0, 0);
    tbl[6]  = mk(0, 5'd1, 12'h000, 1, 10'h010, 0, 1, 1, 12'h010, 0, 0);
    tbl[7]  = mk(0, 5'd1, 12'h000, 1, 10'h011, 0, 1, 1, 12'h011, 0, 0);
    tbl[8]  = mk(0, 5'd1, 12'h000, 1, 10'h012, 0, 1, 1, 12'h012, 0, 0);
    tbl[9]  = mk(0, 5'd1, 12'h000, 1, 10'h013, 0, 1, 1, 12'h013, 1, 1);
    tbl[10] = mk(0, 5'd1, 12'h000, 1, 10'h014, 0, 0, 0, 12'h000, 1, 1);
    tbl[11] = mk(0, 5'd1, 12'h000, 1, 10'h014, 0, 0, 0, 12'h000, 1, 1);
    tbl[12] = mk(0, 5'd1, 12'h000, 1, 10'h014, 1, 0, 0, 12'h000, 1, 1);
    tbl[13] = mk(0, 5'd1, 12'h000, 1, 10'h014, 0, 1, 1, 12'h014, 1, 1);
    tbl[14] = mk(0, 5'd1, 12'h000, 1, 10'h015, 0, 0, 0, 12'h000, 1, 1);
    tbl[15] = mk(0, 5'd1, 12'h000, 0, 10'h000, 1, 0, 0, 12'h000, 1, 1);
    tbl[16] = mk(0, 5'd1, 12'h000, 0, 10'h000, 1, 1, 0, 12'h000, 1, 1);
    tbl[17] = mk(0, 5'd1, 12'h000, 0, 10'h000, 1, 1, 0, 12'h000, 1, 1);
    tbl[18] = mk(0, 5'd1, 12'h000, 0, 10'h000, 1, 1, 0, 12'h000, 1, 1);
    tbl[19] = mk(0, 5'd1, 12'h000, 0, 10'h000, 1, 1, 0, 12'h000, 0, 0);
    // address wrap-around
    tbl[20] = mk(0, 5'd1, 12'hFF0, 1, 10'h020, 1, 1, 1, 12'h010, 0, 0);
    tbl[21] = mk(0, 5'd1, 12'hFF0, 0, 10'h000, 1, 1, 0, 12'h000, 0, 0);
    tbl[22] = mk(0, 5'd1, 12'hFF0, 0, 10'h000, 1, 1, 0, 12'h000, 0, 0);
    tbl[23] = mk(0, 5'd1, 12'hFF0, 0, 10'h000, 1, 1, 0, 12'h000, 1, 1);
    tbl[24] = mk(0, 5'd1, 12'hFF0, 0, 10'h000, 1, 1, 0, 12'h000, 0, 0);

    rst_n = 1'b0; Rst = 1'b0; CfgBaseAddr = 12'h100; CfgK = 5'd4;
    AddrVld = 1'b1; Addr = 10'h005; OfmRdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_addr_rdy", 512'(AddrRdy), 512'(1'b0));
    chk("rst_rd_en", 512'(RdEn), 512'(1'b0));
    chk("rst_ofm_vld", 512'(OfmVld), 512'(1'b0));
    chk("rst_ofm_last", 512'(OfmLast), 512'(1'b0));
    adv();
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      Rst = tbl[i].rst; CfgK = tbl[i].k; CfgBaseAddr = tbl[i].base;
      AddrVld = tbl[i].vld; Addr = tbl[i].addr; OfmRdy = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("v%0d_addr_rdy", i), 512'(AddrRdy), 512'(tbl[i].e_rdy));
      chk($sformatf("v%0d_rd_en", i), 512'(RdEn), 512'(tbl[i].e_en));
      if (tbl[i].e_en) chk($sformatf("v%0d_rd_addr", i), 512'(RdAddr), 512'(tbl[i].e_raddr));
      chk($sformatf("v%0d_ofm_vld", i), 512'(OfmVld), 512'(tbl[i].e_ovld));
      chk($sformatf("v%0d_ofm_last", i), 512'(OfmLast), 512'(tbl[i].e_last));
      adv();
    end
    chk("tbl_drained", 512'(exp_q.size()), 512'(0));

    // 12 back-to-back requests, K=4: no bubbles, last on beats 4/8/12
    rst_pulse(5'd4, 12'h100);
    OfmRdy = 1'b1;
    pops0 = n_pop;
    for (int i = 0; i < 15; i++) begin
      AddrVld = (i < 12); Addr = 10'(10'h040 + i);
      @(negedge clk);
      if (i < 12) chk($sformatf("tp%0d_addr_rdy", i), 512'(AddrRdy), 512'(1'b1));
      if (i >= 3) chk($sformatf("tp%0d_ofm_vld", i), 512'(OfmVld), 512'(1'b1));
      adv();
    end
    AddrVld = 1'b0;
    repeat (3) begin @(negedge clk); adv(); end
    chk("tp_pop_count", 512'(n_pop - pops0), 512'(12));

    // soft clear with two reads in flight and one vector buffered
    rst_pulse(5'd3, 12'h200);
    OfmRdy = 1'b0;
    AddrVld = 1'b1; Addr = 10'h001; @(negedge clk); adv();
    AddrVld = 1'b0;                 @(negedge clk); adv();
    AddrVld = 1'b1; Addr = 10'h002; @(negedge clk); adv();
    Addr = 10'h003; @(negedge clk);
    chk("pre_rst_buffered", 512'(OfmVld), 512'(1'b1));
    adv();
    AddrVld = 1'b0; Rst = 1'b1; @(negedge clk);
    chk("in_rst_ofm_vld", 512'(OfmVld), 512'(1'b0));
    adv();
    Rst = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      AddrVld = 1'b1; Addr = 10'(7 + acc);
      @(negedge clk);
      if (i < 3) chk($sformatf("post_rst%0d_ofm_vld", i), 512'(OfmVld), 512'(1'b0));
      if (AddrVld && AddrRdy) acc++;
      adv();
    end
    chk("post_rst_credits", 512'(acc), 512'(4));
    AddrVld = 1'b0; OfmRdy = 1'b1;
    repeat (8) begin @(negedge clk); adv(); end
    chk("post_rst_drained", 512'(exp_q.size()), 512'(0));

    // random traffic against the scoreboard, two group sizes
    for (int ph = 0; ph < 2; ph++) begin
      rst_pulse(ph == 0 ? 5'd5 : 5'd0, ph == 0 ? 12'h3A0 : 12'hE00);
      for (int c = 0; c < (ph == 0 ? 8000 : 2000); c++) begin
        Rst = ($urandom_range(0, 499) == 0);
        AddrVld = 1'($urandom_range(0, 1));
        Addr = 10'($urandom);
        OfmRdy = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        adv();
      end
      Rst = 1'b0; AddrVld = 1'b0; OfmRdy = 1'b1;
      repeat (10) begin @(negedge clk); adv(); end
      chk($sformatf("rand%0d_drained", ph), 512'(exp_q.size()), 512'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
